// File: rtl/axi_burst_write_master.sv
// Single-outstanding AXI write master: takes one local command, checks it, runs AW/W/B to completion
// and reports a one-cycle completion status (OKAY/EXOKAY/SLVERR/DECERR/BAD_CMD/BID_MISMATCH/TIMEOUT).
module axi_burst_write_master #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int ID_W        = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [3:0]        cmd_len,
   input  logic [2:0]        cmd_size,
   input  logic [1:0]        cmd_burst,
   input  logic [ID_W-1:0]   cmd_id,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              done_valid,
   output logic [2:0]        done_status,
   output logic              busy,
   output logic [ID_W-1:0]   AWID,
   output logic [ADDR_W-1:0] AWADDR,
   output logic [3:0]        AWLEN,
   output logic [2:0]        AWSIZE,
   output logic [1:0]        AWBURST,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [ID_W-1:0]   WID,
   output logic [DATA_W-1:0] WDATA,
   output logic [DATA_W/8-1:0] WSTRB,
   output logic              WLAST,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic [ID_W-1:0]   BID,
   input  logic [1:0]        BRESP,
   input  logic              BVALID,
   output logic              BREADY
);

   localparam int NB     = DATA_W / 8;
   localparam int LANE_W = $clog2(NB);
   localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [2:0]      MAX_SIZE = 3'($clog2(NB));

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ADDR, S_DATA, S_RESP, S_DONE
   } state_t;

   state_t state_reg, state_next;

   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] beat_addr_reg;
   logic [3:0]        len_reg;
   logic [3:0]        beat_cnt_reg;
   logic [2:0]        size_reg;
   logic [1:0]        burst_reg;
   logic [ID_W-1:0]   id_reg;
   logic [WD_W-1:0]   wdog_reg;
   logic [2:0]        status_reg;

   // command legality
   logic [ADDR_W-1:0] bytes_a;
   logic [ADDR_W-1:0] align_mask;
   logic [12:0]       total13;
   logic              cross_4k;
   logic              size_bad;
   logic              wrap_len_bad;
   logic              wrap_unaligned;
   logic              cmd_bad;

   assign bytes_a        = ADDR_W'(1) << size_reg;
   assign align_mask     = ~(bytes_a - ADDR_W'(1));
   assign total13        = (13'(len_reg) + 13'd1) << size_reg;
   // the burst's last byte lands past the page when aligned_start + total_bytes exceeds 4096
   assign cross_4k       = ({1'b0, addr_reg[11:0] & align_mask[11:0]} + total13) > 13'd4096;
   assign size_bad       = size_reg > MAX_SIZE;
   assign wrap_len_bad   = !(len_reg inside {4'd1, 4'd3, 4'd7, 4'd15});
   assign wrap_unaligned = |(addr_reg & ~align_mask);
   assign cmd_bad        = (burst_reg == BURST_RSVD) || size_bad
                        || ((burst_reg == BURST_WRAP) && (wrap_len_bad || wrap_unaligned))
                        || ((burst_reg == BURST_INCR) && cross_4k);

   // next beat address
   logic [ADDR_W-1:0] wrap_bytes;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] next_addr;

   assign wrap_bytes = bytes_a * (ADDR_W'(len_reg) + ADDR_W'(1));
   assign wrap_mask  = wrap_bytes - ADDR_W'(1);

   always_comb begin
      next_addr = beat_addr_reg;
      case (burst_reg)
         BURST_INCR: next_addr = (beat_addr_reg & align_mask) + bytes_a;
         BURST_WRAP: next_addr = (beat_addr_reg & ~wrap_mask)
                               | ((beat_addr_reg + bytes_a) & wrap_mask);
         default:    next_addr = beat_addr_reg;
      endcase
   end

   // byte strobes: lanes from the beat address up to the end of its size-aligned container
   logic [7:0]    bytes8;
   logic [7:0]    lane8;
   logic [7:0]    lane_al8;
   logic [7:0]    lane_end8;
   logic [NB-1:0] strb;

   assign bytes8    = 8'd1 << size_reg;
   assign lane8     = 8'(beat_addr_reg[LANE_W-1:0]);
   assign lane_al8  = lane8 & ~(bytes8 - 8'd1);
   assign lane_end8 = lane_al8 + bytes8;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_strb
         assign strb[gi] = (8'(gi) >= lane8) && (8'(gi) < lane_end8);
      end
   endgenerate

   logic last_beat;
   logic wd_expire;

   assign last_beat = (beat_cnt_reg == len_reg);
   assign wd_expire = (TIMEOUT_CYC != 0) && (wdog_reg == WD_LAST);

   // state register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state_reg <= S_IDLE;
      else          state_reg <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (cmd_valid) state_next = S_CHECK;
         S_CHECK: state_next = cmd_bad ? S_DONE : S_ADDR;
         S_ADDR:  if (AWREADY) state_next = S_DATA;
         S_DATA:  if (wr_valid && WREADY && last_beat) state_next = S_RESP;
         S_RESP:  if (BVALID || wd_expire) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // command, beat tracking, watchdog and status
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addr_reg      <= '0;
         beat_addr_reg <= '0;
         len_reg       <= '0;
         beat_cnt_reg  <= '0;
         size_reg      <= '0;
         burst_reg     <= '0;
         id_reg        <= '0;
         wdog_reg      <= '0;
         status_reg    <= '0;
      end else begin
         wdog_reg <= (state_reg == S_RESP) ? wdog_reg + WD_W'(1) : '0;
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  addr_reg      <= cmd_addr;
                  beat_addr_reg <= cmd_addr;
                  len_reg       <= cmd_len;
                  size_reg      <= cmd_size;
                  burst_reg     <= cmd_burst;
                  id_reg        <= cmd_id;
                  beat_cnt_reg  <= '0;
                  status_reg    <= 3'd0;
               end
            end
            S_CHECK: if (cmd_bad) status_reg <= 3'd4;
            S_DATA: begin
               if (wr_valid && WREADY) begin
                  beat_cnt_reg  <= beat_cnt_reg + 4'd1;
                  beat_addr_reg <= next_addr;
               end
            end
            S_RESP: begin
               // a response arriving on the expiry cycle still takes precedence
               if (BVALID)         status_reg <= (BID != id_reg) ? 3'd5 : {1'b0, BRESP};
               else if (wd_expire) status_reg <= 3'd6;
            end
            default: ;
         endcase
      end
   end

   assign AWID        = id_reg;
   assign AWADDR      = addr_reg;
   assign AWLEN       = len_reg;
   assign AWSIZE      = size_reg;
   assign AWBURST     = burst_reg;
   assign WID         = id_reg;
   assign done_status = status_reg;

   // outputs
   always_comb begin
      cmd_ready  = 1'b0;
      busy       = 1'b1;
      AWVALID    = 1'b0;
      wr_ready   = 1'b0;
      WVALID     = 1'b0;
      WDATA      = '0;
      WSTRB      = '0;
      WLAST      = 1'b0;
      BREADY     = 1'b0;
      done_valid = 1'b0;
      case (state_reg)
         S_IDLE: begin
            cmd_ready = 1'b1;
            BREADY    = 1'b1;
            busy      = 1'b0;
         end
         S_ADDR: AWVALID = 1'b1;
         S_DATA: begin
            wr_ready = WREADY;
            WVALID   = wr_valid;
            WDATA    = wr_data;
            WSTRB    = strb;
            WLAST    = last_beat;
         end
         S_RESP:  BREADY = 1'b1;
         S_DONE:  done_valid = 1'b1;
         default: ;
      endcase
   end

endmodule
